// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with word-serial line refill and a sequential flush.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instruction_cache #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned WORD_BITS  = 2
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [31:0] imem_address_i,
    input  logic        imem_read_i,
    output logic [31:0] imem_data_o,
    output logic        imem_data_ready_o,
    input  logic        invalidate_i,
    output logic [31:0] mem_address_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);
    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned WORDS    = 1 << WORD_BITS;
    localparam int unsigned TAG_LSB  = INDEX_BITS + WORD_BITS + 2;
    localparam int unsigned TAG_BITS = 32 - TAG_LSB;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;
    state_t state_q, state_d;

    logic                  req_q, req_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic [WORD_BITS-1:0]  off_q, off_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [INDEX_BITS-1:0] fill_idx_q, fill_idx_d;
    logic [TAG_BITS-1:0]   fill_tag_q, fill_tag_d;
    logic [WORD_BITS-1:0]  beat_q, beat_d;
    logic [INDEX_BITS-1:0] flush_idx_q, flush_idx_d;
    logic                  pending_q, pending_d;
    logic [LINES-1:0]      valid_q, valid_d;

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];

    logic lookup, hit, miss, last_beat;
    logic unused_addr_bits;

    assign unused_addr_bits = ^imem_address_i[1:0];

    // A registered request is only looked up if it was accepted while IDLE.
    always_comb begin
        lookup    = (state_q == S_IDLE) && req_q;
        hit       = lookup && valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
        miss      = lookup && !hit;
        last_beat = (state_q == S_FILL) && mem_ack_i && (beat_q == '1);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (invalidate_i) begin
                    state_d = S_FLUSH;
                end else if (miss) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (last_beat) begin
                    state_d = (pending_q || invalidate_i) ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: begin
                if (flush_idx_q == '1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_data_ready_o = hit;
        imem_data_o       = hit ? data_mem[{idx_q, off_q}] : '0;
        mem_read_o        = (state_q == S_FILL);
        mem_address_o     = (state_q == S_FILL) ? {fill_tag_q, fill_idx_q, beat_q, 2'b00} : '0;
    end

    always_comb begin
        req_d       = imem_read_i && (state_q == S_IDLE) && !invalidate_i;
        idx_d       = idx_q;
        off_d       = off_q;
        tag_d       = tag_q;
        fill_idx_d  = fill_idx_q;
        fill_tag_d  = fill_tag_q;
        beat_d      = beat_q;
        flush_idx_d = (state_q == S_FLUSH) ? flush_idx_q + INDEX_BITS'(1) : '0;
        pending_d   = ((state_q == S_FILL) && !last_beat) ? (pending_q || invalidate_i) : 1'b0;
        valid_d     = valid_q;
        if (req_d) begin
            idx_d = imem_address_i[TAG_LSB-1:WORD_BITS+2];
            off_d = imem_address_i[WORD_BITS+1:2];
            tag_d = imem_address_i[31:TAG_LSB];
        end
        if (miss && !invalidate_i) begin
            fill_idx_d = idx_q;
            fill_tag_d = tag_q;
            beat_d     = '0;
        end
        if ((state_q == S_FILL) && mem_ack_i) begin
            beat_d = beat_q + WORD_BITS'(1);
        end
        if (last_beat) begin
            valid_d[fill_idx_q] = 1'b1;
        end
        if (state_q == S_FLUSH) begin
            valid_d[flush_idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_q       <= 1'b0;
            idx_q       <= '0;
            off_q       <= '0;
            tag_q       <= '0;
            fill_idx_q  <= '0;
            fill_tag_q  <= '0;
            beat_q      <= '0;
            flush_idx_q <= '0;
            pending_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            req_q       <= req_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            tag_q       <= tag_d;
            fill_idx_q  <= fill_idx_d;
            fill_tag_q  <= fill_tag_d;
            beat_q      <= beat_d;
            flush_idx_q <= flush_idx_d;
            pending_q   <= pending_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock_i) begin
        if ((state_q == S_FILL) && mem_ack_i) begin
            data_mem[{fill_idx_q, beat_q}] <= mem_data_i;
        end
        if (last_beat) begin
            tag_mem[fill_idx_q] <= fill_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + 32'(hit);
        miss_count_d = miss_count_q + 32'(miss && !invalidate_i);
        hit_count_o  = hit_count_q;
        miss_count_o = miss_count_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus random traffic,
// compared against an address-arithmetic model of the cache contents.
module tb_instruction_cache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        invalidate;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_data;
    logic        mem_ack;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_cache #(.INDEX_BITS(6), .WORD_BITS(2)) dut (
        .clock_i          (clk),
        .reset_n_i        (rst_n),
        .imem_address_i   (imem_address),
        .imem_read_i      (imem_read),
        .imem_data_o      (imem_data),
        .imem_data_ready_o(imem_ready),
        .invalidate_i     (invalidate),
        .mem_address_o    (mem_address),
        .mem_read_o       (mem_read),
        .mem_data_i       (mem_data),
        .mem_ack_i        (mem_ack)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count_o      (hit_count),
        .miss_count_o     (miss_count)
`endif
    );

    typedef enum {M_IDLE, M_FILL, M_FLUSH} mmode_t;
    mmode_t      m_mode;
    bit          m_valid [64];
    bit   [31:0] m_tag [64];
    logic [31:0] m_data [64][4];
    bit          m_req;
    logic [31:0] m_req_addr;
    logic [31:0] m_fill_base;
    int          m_beat;
    bit          m_pend;
    int          m_flush_left;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) & 32'h3F);
    endfunction
    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h3);
    endfunction
    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> 10;
    endfunction
    // Backing memory: word at byte address 0x100 + 4k reads 0xA0 + k, unique everywhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + (a >> 2) - 32'h40;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_req = 1'b0; m_req_addr = '0; m_fill_base = '0;
        m_beat = 0; m_pend = 1'b0; m_flush_left = 0; m_hits = '0; m_misses = '0;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endfunction

    function automatic bit model_hit();
        int l;
        l = line_of(m_req_addr);
        return (m_mode == M_IDLE) && m_req && m_valid[l] && (m_tag[l] == tag_of(m_req_addr));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit h;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        h = model_hit();
        exp_data = h ? m_data[line_of(m_req_addr)][word_of(m_req_addr)] : 32'h0;
        exp_addr = (m_mode == M_FILL) ? m_fill_base + 32'(4 * m_beat) : 32'h0;
        check("ready", 32'(imem_ready), 32'(h));
        check("data", imem_data, exp_data);
        check("mem_read", 32'(mem_read), 32'(m_mode == M_FILL));
        check("mem_addr", mem_address, exp_addr);
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the same cycle, then move past the edge.
    task automatic step(input bit rd, input logic [31:0] addr, input bit inv, input bit ack);
        bit h;
        bit miss;
        mmode_t old_mode;
        logic [31:0] beat_addr;
        imem_read = rd; imem_address = addr; invalidate = inv; mem_ack = ack;
        beat_addr = m_fill_base + 32'(4 * m_beat);
        mem_data = mem_word(beat_addr);
        h = model_hit();
        miss = (m_mode == M_IDLE) && m_req && !h;
        old_mode = m_mode;
        if (h) m_hits++;
        case (m_mode)
            M_IDLE: begin
                if (inv) begin
                    m_mode = M_FLUSH; m_flush_left = 64;
                end else if (miss) begin
                    m_mode = M_FILL; m_fill_base = m_req_addr & ~32'hF;
                    m_beat = 0; m_pend = 1'b0; m_misses++;
                end
            end
            M_FILL: begin
                if (inv) m_pend = 1'b1;
                if (ack) begin
                    m_data[line_of(beat_addr)][m_beat] = mem_data;
                    m_beat++;
                    if (m_beat == 4) begin
                        m_valid[line_of(m_fill_base)] = 1'b1;
                        m_tag[line_of(m_fill_base)] = tag_of(m_fill_base);
                        if (m_pend) begin
                            m_mode = M_FLUSH; m_flush_left = 64;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
            default: begin
                m_flush_left--;
                if (m_flush_left == 0) begin
                    foreach (m_valid[i]) m_valid[i] = 1'b0;
                    m_mode = M_IDLE;
                end
            end
        endcase
        m_req = (old_mode == M_IDLE) && rd && !inv;
        m_req_addr = addr;
        @(posedge clk);
        #1;
    endtask

    // Hold a read until ready returns; measures the first refill seen on the memory side.
    task automatic read_until_ready(input logic [31:0] addr, input logic [31:0] redir_addr,
                                    input int redir_at, input int ack_period, input int budget,
                                    output int fill_cycles, output logic [31:0] first_addr,
                                    output bit done);
        int phase;
        bit in_first;
        bit first_over;
        bit redirected;
        bit ack;
        phase = 0; in_first = 1'b0; first_over = 1'b0; redirected = 1'b0;
        fill_cycles = 0; first_addr = '0; done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            check_outputs();
            if (t > 0 && imem_ready) begin
                done = 1'b1;
            end else begin
                if (mem_read && !first_over) begin
                    if (!in_first) first_addr = mem_address;
                    in_first = 1'b1;
                    fill_cycles++;
                end else if (in_first) begin
                    first_over = 1'b1;
                end
                if (in_first && fill_cycles > redir_at) redirected = 1'b1;
                ack = 1'b0;
                if (m_mode == M_FILL) begin
                    ack = ((phase % ack_period) == ack_period - 1);
                    phase++;
                end
                step(1'b1, redirected ? redir_addr : addr, 1'b0, ack);
            end
        end
    endtask

    initial begin
        int fc;
        logic [31:0] fa;
        bit done;
        int st;
        int gap;
        logic [31:0] ra;

        rst_n = 1'b0; imem_read = 1'b0; imem_address = '0; invalidate = 1'b0;
        mem_ack = 1'b0; mem_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Cold miss on 0x100 with the read held and an ack every cycle.
        for (int t = 0; t < 8; t++) begin
            check_outputs();
            if (t >= 1 && t <= 6) check("cold_ready_low", 32'(imem_ready), 32'h0);
            if (t >= 2 && t <= 5) check("cold_beat_addr", mem_address, 32'h100 + 32'(4 * (t - 2)));
            if (t == 7) begin
                check("cold_ready", 32'(imem_ready), 32'h1);
                check("cold_data", imem_data, 32'hA0);
            end
            step(1'b1, 32'h100, 1'b0, 1'b1);
        end

        // Hits streaming back-to-back from the filled line.
        for (int k = 1; k <= 4; k++) begin
            check_outputs();
            check("stream_ready", 32'(imem_ready), 32'h1);
            check("stream_data", imem_data, 32'hA0 + 32'(k - 1));
            if (k <= 3) step(1'b1, 32'h100 + 32'(4 * k), 1'b0, 1'b0);
            else        step(1'b0, 32'h0, 1'b0, 1'b0);
        end

        // Conflict: same index, different tag.
        read_until_ready(32'h500, 32'h500, 1000, 1, 40, fc, fa, done);
        check("conflict_done", 32'(done), 32'h1);
        check("conflict_refill_addr", fa, 32'h500);
        check("conflict_fill_cycles", 32'(fc), 32'h4);
        check("conflict_data", imem_data, 32'h1A0);

        // 0x100 now misses; slow memory and a redirect to 0x200 during the refill.
        read_until_ready(32'h100, 32'h200, 4, 3, 80, fc, fa, done);
        check("wait_done", 32'(done), 32'h1);
        check("wait_refill_addr", fa, 32'h100);
        check("wait_fill_cycles", 32'(fc), 32'd12);
        check("redirect_data", imem_data, 32'hE0);
        read_until_ready(32'h100, 32'h100, 1000, 1, 10, fc, fa, done);
        check("after_redirect_done", 32'(done), 32'h1);
        check("after_redirect_hit", 32'(fc), 32'h0);
        check("after_redirect_data", imem_data, 32'hA0);

        // Invalidate during the second beat of a refill of 0x300.
        st = 0; gap = 0;
        for (int t = 0; t < 150 && st < 3; t++) begin
            check_outputs();
            if (st == 0 && mem_read) st = 1;
            else if (st == 1 && !mem_read) st = 2;
            if (st == 2) begin
                if (mem_read) st = 3;
                else gap++;
            end
            if (st < 3) step(1'b1, 32'h300, (st == 1) && (m_mode == M_FILL) && (m_beat == 1), 1'b1);
        end
        check("flush_gap_end", 32'(st), 32'h3);
        check("flush_gap", 32'(gap), 32'd66);
        read_until_ready(32'h300, 32'h300, 1000, 1, 20, fc, fa, done);
        check("post_flush_300_done", 32'(done), 32'h1);
        read_until_ready(32'h100, 32'h100, 1000, 1, 20, fc, fa, done);
        check("post_flush_done", 32'(done), 32'h1);
        check("post_flush_miss", 32'(fc), 32'h4);
        check("post_flush_refill_addr", fa, 32'h100);

        // Reset asserted during the first beat of a refill.
        for (int t = 0; t < 6 && !mem_read; t++) begin
            check_outputs();
            step(1'b1, 32'h600, 1'b0, 1'b0);
        end
        check("rst_fill_started", 32'(mem_read), 32'h1);
        rst_n = 1'b0; imem_read = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("rst_mem_read", 32'(mem_read), 32'h0);
        check("rst_ready", 32'(imem_ready), 32'h0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_until_ready(32'h100, 32'h100, 1000, 1, 20, fc, fa, done);
        check("post_reset_done", 32'(done), 32'h1);
        check("post_reset_miss", 32'(fc), 32'h4);
        check("post_reset_data", imem_data, 32'hA0);

        // Random traffic over a few lines and tags with occasional invalidates.
        for (int t = 0; t < 2000; t++) begin
            check_outputs();
            ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
               | 32'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, ra, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) != 0);
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache.
- Sits between the instruction fetch stage and the external memory bus.
- Responds to the fetch stage's single-cycle imem read protocol: address plus read strobe in cycle N, data plus ready in cycle N+1.
- On a miss it refills one full line from memory with a word-serial handshake. The requester re-presents the same address until ready is returned.

Parameters:
- INDEX_BITS, 6, log2 of number of lines (64 lines).
- WORD_BITS, 2, log2 of words per line (4 words = 16 bytes/line).

Ports:
- clock_i  in  1  clock, all state on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- imem_address_i  in  32  byte address from fetch. Bits [1:0] are ignored.
- imem_read_i  in  1  read request this cycle.
- imem_data_o  out  32  instruction word; valid when imem_data_ready_o=1, else 0.
- imem_data_ready_o  out  1  previous cycle's read hit.
- invalidate_i  in  1  single-cycle pulse; clear all valid bits.
- mem_address_o  out  32  word address (byte units, [1:0]=0) of refill beat.
- mem_read_o  out  1  refill request, held until the last ack.
- mem_data_i  in  32  refill data, valid with mem_ack_i.
- mem_ack_i  in  1  one refill word accepted/returned this cycle.

Behaviour:
- Address split:
  - offset = addr[WORD_BITS+1:2]
  - index = addr[WORD_BITS+INDEX_BITS+1:WORD_BITS+2]
  - tag = the remaining upper bits
- Storage: per-line valid bit, tag, and 2^WORD_BITS data words. Valid bits are flops cleared by reset; tag and data arrays are not reset.
- Reset values: state=IDLE, all valid=0, imem_data_o=0, imem_data_ready_o=0, mem_read_o=0, mem_address_o=0. Reset asserted mid-fill aborts the fill immediately with no line validated.
- FSM states IDLE, FILL, FLUSH.
- IDLE, lookup:
  - The read in cycle N registers the index, offset and tag.
  - In cycle N+1, hit = valid & tag match. If hit, imem_data_ready_o=1 and imem_data_o = the word; latency is 1.
  - If no read in cycle N, ready=0 in N+1.
- Miss at N+1: ready=0. Next state is FILL with mem_address_o = line base (offset zeroed) and mem_read_o=1 from N+2.
- FILL:
  - Each cycle with mem_ack_i=1, mem_data_i is written to the word at the current beat and mem_address_o advances by 4.
  - On the ack of the last beat, the tag is written, valid=1, mem_read_o drops, and the next state is IDLE.
  - mem_ack_i=0 inserts wait cycles with no limit; address and read are held.
  - Reads presented during FILL, including the final-ack cycle, get ready=0 in the following cycle and are not queued. The requester retries.
  - Any address change by the requester during FILL (branch redirect) has no effect on the fill in progress.
- FLUSH:
  - invalidate_i in IDLE enters FLUSH next cycle.
  - A line counter clears one valid bit per cycle, 2^INDEX_BITS cycles total, then returns to IDLE.
  - Reads during FLUSH return ready=0.
  - invalidate_i together with a read in IDLE: flush wins and that read gets ready=0.
- invalidate_i during FILL: latched as pending. The fill completes and validates its line, then FLUSH runs.
- invalidate_i during FLUSH: ignored, because the flush in progress already covers all lines.
- A hit to a line just filled in the same cycle is impossible by construction: the first hit is the read presented in the first IDLE cycle after FILL.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, two extra output ports are added: hit_count_o (32) and miss_count_o (32).
  - Each counts lookups resolved in IDLE: +1 per ready=1 and +1 per miss that enters FILL.
  - Both cleared by reset, wrap at 2^32, and not cleared by invalidate_i.
  - Reads rejected during FILL or FLUSH are not counted.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold miss, ack every cycle. Read 0x100 held from cycle 0 with memory word k = 0xA0+k:
  - ready=0 at cycles 1–6.
  - mem_read_o=1 with addresses 0x100/104/108/10C in cycles 2–5.
  - ready=1 with data 0xA0 at cycle 7.
- Hit streaming: after the fill, reads 0x104, 0x108, 0x10C on consecutive cycles -> ready=1 each following cycle with data 0xA1, 0xA2, 0xA3.
- Conflict: read 0x500 (same index as 0x100, different tag) -> miss and refill from 0x500. A later read of 0x100 misses again.
- Wait states: mem_ack_i only every third cycle -> mem_address_o holds between acks and the 4 beats complete in 12 cycles. Redirecting the read to 0x200 mid-fill does not disturb the 0x100 line.
- Invalidate mid-fill: pulse during beat 2 -> fill completes, FLUSH lasts 64 cycles, then read 0x100 misses.
- Reset mid-fill: assert reset_n_i low during beat 1 -> mem_read_o=0 and ready=0 immediately. After release, read 0x100 misses. With ICACHE_STATS_EN both counters read 0.
